// File: rtl/fp_norm_round.sv
// Normalise, round-to-nearest-even and pack stage for the binary32 mantissa adder result.
// Build option FP_NORM_FAST_EN: single-cycle leading-zero normalisation instead of one shift per cycle.
module fp_norm_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inexact
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in OUT, and OUT holds until the transfer.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [8:0]  e_q, e_d;
    logic [26:0] m_q, m_d;
    logic        zero_q, zero_d;
    logic        nz_in_q, nz_in_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        inexact_q, inexact_d;

    logic        rnd_lsb, rnd_g, rnd_s, rnd_inc;
    logic [24:0] rnd_sum;
    logic        r_int;
    logic [22:0] r_frac;
    logic [8:0]  r_e;

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_OUT);
    assign out_result  = result_q;
    assign out_ovf     = ovf_q;
    assign out_unf     = unf_q;
    assign out_inexact = inexact_q;

    always_comb begin
        rnd_lsb = m_q[2];
        rnd_g   = m_q[1];
        rnd_s   = m_q[0];
        rnd_inc = rnd_g & (rnd_s | rnd_lsb);
        rnd_sum = {1'b0, m_q[25:2]} + {24'b0, rnd_inc};
        // A carry out of the integer bit renormalises by one position.
        if (rnd_sum[24]) begin
            r_int  = 1'b1;
            r_frac = rnd_sum[23:1];
            r_e    = e_q + 9'd1;
        end else begin
            r_int  = rnd_sum[23];
            r_frac = rnd_sum[22:0];
            r_e    = e_q;
        end
    end

`ifdef FP_NORM_FAST_EN
    logic [4:0] lzc;
    logic [8:0] sh;

    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (m_q[i]) lzc = 5'(25 - i);
        end
        // Never shift the exponent below 1; the remainder stays denormal.
        if ({4'b0, lzc} < (e_q - 9'd1)) sh = {4'b0, lzc};
        else                            sh = e_q - 9'd1;
    end
`endif

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        e_d       = e_q;
        m_d       = m_q;
        zero_d    = zero_q;
        nz_in_d   = nz_in_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inexact_d = inexact_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    e_d     = (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
                    m_d     = in_mant;
                    zero_d  = 1'b0;
                    nz_in_d = |in_mant;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (m_q[26]) begin
                    m_d     = {1'b0, m_q[26:2], m_q[1] | m_q[0]};
                    e_d     = e_q + 9'd1;
                    state_d = ST_ROUND;
                end else if (m_q[25:0] == 26'd0) begin
                    zero_d  = 1'b1;
                    state_d = ST_ROUND;
                end else if (m_q[25]) begin
                    state_d = ST_ROUND;
`ifdef FP_NORM_FAST_EN
                end else begin
                    m_d     = m_q << sh;
                    e_d     = e_q - sh;
                    state_d = ST_ROUND;
                end
`else
                end else if (e_q <= 9'd1) begin
                    state_d = ST_ROUND;
                end else begin
                    m_d = {m_q[25:0], 1'b0};
                    e_d = e_q - 9'd1;
                end
`endif
            end
            ST_ROUND: begin
                ovf_d     = 1'b0;
                unf_d     = 1'b0;
                inexact_d = rnd_g | rnd_s;
                if (zero_q) begin
                    result_d = 32'h0000_0000;
                    unf_d    = nz_in_q;
                end else if (r_e >= 9'd255) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                    ovf_d    = 1'b1;
                end else if (!r_int) begin
                    result_d = {sign_q, 8'h00, r_frac};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, r_e[7:0], r_frac};
                end
                state_d = ST_OUT;
            end
            default: begin
                if (out_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            e_q       <= 9'd0;
            m_q       <= 27'd0;
            zero_q    <= 1'b0;
            nz_in_q   <= 1'b0;
            result_q  <= 32'd0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            e_q       <= e_d;
            m_q       <= m_d;
            zero_q    <= zero_d;
            nz_in_q   <= nz_in_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inexact_q <= inexact_d;
        end
    end
endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed vectors with hand-computed results, flags and latency.
module tb_fp_norm_round;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    int errors = 0;
    int checks = 0;
    logic [34:0] exp_q[$];
    int          lat_q[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        ov_prev = 1'b0;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf),
        .out_inexact(out_inexact)
    );

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_cyc <= cyc + 1;
    end

    // Monitor: latency on the first OUT cycle, result and flags on the handshake.
    always @(negedge clk) begin
        logic [34:0] e;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (lat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual=%h required=none", out_result);
                end else begin
                    check("latency", 35'(cyc - acc_cyc), 35'(lat_q[0]));
                end
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                void'(lat_q.pop_front());
                check("result", {3'b0, out_result}, {3'b0, e[31:0]});
                check("flags", {32'b0, out_ovf, out_unf, out_inexact}, {32'b0, e[34:32]});
            end
            ov_prev = out_valid;
        end
    end

    // expv = {ovf, unf, inexact, result}; n = left shifts in iterative mode.
    task automatic send(input logic s, input logic [7:0] ex, input logic [26:0] m,
                        input logic [34:0] expv, input int n, input bit push);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: actual=0 required=1");
            return;
        end
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = ex;
        in_mant  = m;
        if (push) begin
            exp_q.push_back(expv);
`ifdef FP_NORM_FAST_EN
            lat_q.push_back(2);
`else
            lat_q.push_back(2 + n);
`endif
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_mant   = 27'd0;
        out_ready = 1'b1;
        #1;
        check("reset_in_ready", {34'b0, in_ready}, 35'd1);
        check("reset_out_valid", {34'b0, out_valid}, 35'd0);
        check("reset_result", {3'b0, out_result}, 35'd0);
        check("reset_flags", {32'b0, out_ovf, out_unf, out_inexact}, 35'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        send(1'b0, 8'd127, 27'h4000000, {3'b000, 32'h4000_0000}, 0, 1'b1);
        send(1'b0, 8'd130, 27'h0000004, {3'b000, 32'h3580_0000}, 23, 1'b1);
        send(1'b0, 8'd127, 27'h2000006, {3'b001, 32'h3F80_0002}, 0, 1'b1);
        send(1'b0, 8'd127, 27'h2000002, {3'b001, 32'h3F80_0000}, 0, 1'b1);
        send(1'b0, 8'd254, 27'h4000000, {3'b100, 32'h7F80_0000}, 0, 1'b1);
        send(1'b0, 8'd1,   27'h1000000, {3'b010, 32'h0040_0000}, 0, 1'b1);
        send(1'b1, 8'd100, 27'h0000000, {3'b000, 32'h0000_0000}, 0, 1'b1);
        send(1'b1, 8'd128, 27'h2000003, {3'b001, 32'hC000_0001}, 0, 1'b1);
        send(1'b0, 8'd127, 27'h3FFFFFE, {3'b001, 32'h4000_0000}, 0, 1'b1);
        send(1'b0, 8'd0,   27'h2000000, {3'b000, 32'h0080_0000}, 0, 1'b1);
        send(1'b0, 8'd3,   27'h0400000, {3'b010, 32'h0040_0000}, 2, 1'b1);

        // Downstream stall: output must hold and no new input accepted.
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        out_ready = 1'b0;
        send(1'b0, 8'd127, 27'h4000000, {3'b000, 32'h4000_0000}, 0, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("stall_reached_out", {34'b0, out_valid}, 35'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_result", {3'b0, out_result}, {3'b0, 32'h4000_0000});
            check("stall_in_ready", {34'b0, in_ready}, 35'd0);
            check("stall_out_valid", {34'b0, out_valid}, 35'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Reset during NORM aborts the transaction.
        send(1'b0, 8'd130, 27'h0000004, 35'd0, 23, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {34'b0, out_valid}, 35'd0);
        check("abort_in_ready", {34'b0, in_ready}, 35'd1);
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, 8'd127, 27'h2000006, {3'b001, 32'h3F80_0002}, 0, 1'b1);

        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 35'(exp_q.size()), 35'd0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
